// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for up to 16 requesters with index and one-hot grant outputs.
// Optional forced release after MAX_HOLD grant cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_decode_arbiter #(
    parameter int N_REQ    = 16,
    parameter int IDX_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic              done,
    output logic              grant_valid,
    output logic [IDX_W-1:0]  grant_idx,
    output logic [N_REQ-1:0]  grant_onehot,
    output logic [7:0]        grant_cnt,
    output logic              timeout
);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  next_ptr;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  scan_pos;
    logic [N_REQ-1:0]  pick_onehot;
    logic              pick_valid;
    logic              hold_expired;

    if (N_REQ < 2 || N_REQ > 16 || (1 << IDX_W) < N_REQ || MAX_HOLD < 2) begin : g_bad_param
        $error("rr_decode_arbiter: illegal parameter combination");
    end

    // Scan from ptr downward in priority so the lowest offset from ptr wins.
    always_comb begin
        pick_idx   = '0;
        scan_pos   = '0;
        pick_valid = |req;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            scan_pos = IDX_W'((int'(ptr) + off) % N_REQ);
            if (req[scan_pos]) begin
                pick_idx = scan_pos;
            end
        end
    end

    assign pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
    assign next_ptr    = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold_cnt;

    assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    // hold_cnt is zero on the first grant cycle; timeout only fires when done did not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= (state == OWN) && !done && hold_expired;
            if (state == OWN) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`else
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            grant_onehot <= '0;
            grant_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state        <= OWN;
                        grant_valid  <= 1'b1;
                        grant_idx    <= pick_idx;
                        grant_onehot <= pick_onehot;
                        grant_cnt    <= grant_cnt + 8'd1;
                    end
                end
                OWN: begin
                    if (done || hold_expired) begin
                        state        <= IDLE;
                        grant_valid  <= 1'b0;
                        grant_onehot <= '0;
                        ptr          <= next_ptr;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Self-checking bench for rr_decode_arbiter: directed vector table, multi-cycle sequences
// and randomized traffic against a behavioural model (timeout checks follow ARB_TIMEOUT_EN).
module tb_rr_decode_arbiter;

    localparam int N_REQ    = 16;
    localparam int IDX_W    = 4;
    localparam int MAX_HOLD = 8;

    logic              clk;
    logic              rst_n;
    logic [N_REQ-1:0]  req;
    logic              done;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic [N_REQ-1:0]  grant_onehot;
    logic [7:0]        grant_cnt;
    logic              timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        bit          rst;
        logic [15:0] req;
        bit          done;
        bit          exp_valid;
        int          exp_idx;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state: who owns the resource, fairness pointer, counters.
    bit m_own;
    int m_idx;
    int m_ptr;
    int m_cnt;
    int m_age;
    bit m_to;

    rr_decode_arbiter #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .done(done),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx),
        .grant_onehot(grant_onehot),
        .grant_cnt(grant_cnt),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input bit ev, input int ei, input int ec, input bit et);
        logic [15:0] eo;
        logic [3:0]  ei4;
        logic [7:0]  ec8;
        ei4 = ei[3:0];
        ec8 = ec[7:0];
        eo  = ev ? (16'h0001 << ei4) : 16'h0000;
        tests_run++;
        if (grant_valid !== ev || (ev && grant_idx !== ei4) || grant_onehot !== eo ||
            grant_cnt !== ec8 || timeout !== et) begin
            tests_failed++;
            $display("[TB] FAIL %s: got valid=%0b idx=%0d onehot=%h cnt=%0d timeout=%0b, expected valid=%0b idx=%0d onehot=%h cnt=%0d timeout=%0b",
                     name, grant_valid, grant_idx, grant_onehot, grant_cnt, timeout,
                     ev, ei4, eo, ec8, et);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] r, input bit d);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        #2;
        checkOutput("reset", 1'b0, 0, 0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_own = 1'b0;
        m_idx = 0;
        m_ptr = 0;
        m_cnt = 0;
        m_age = 0;
        m_to  = 1'b0;
    endtask

    // Winner = first requester at or after the pointer, found by rotating the vector.
    task automatic modelUpdate(input logic [15:0] r, input bit d);
        logic [31:0] rot;
        int          pos;
        m_to = 1'b0;
        if (!m_own) begin
            if (r != 16'h0) begin
                rot = {r, r} >> m_ptr;
                pos = 0;
                for (int k = 15; k >= 0; k--) begin
                    if (rot[k]) pos = k;
                end
                m_idx = (m_ptr + pos) % N_REQ;
                m_own = 1'b1;
                m_cnt = (m_cnt + 1) % 256;
                m_age = 1;
            end
        end else if (d) begin
            m_own = 1'b0;
            m_ptr = (m_idx + 1) % N_REQ;
`ifdef ARB_TIMEOUT_EN
        end else if (m_age >= MAX_HOLD) begin
            m_own = 1'b0;
            m_ptr = (m_idx + 1) % N_REQ;
            m_to  = 1'b1;
`endif
        end else begin
            m_age = m_age + 1;
        end
    endtask

    function automatic void addVec(input bit rs, input logic [15:0] r, input bit d,
                                   input bit ev, input int ei, input int ec);
        vec_t v;
        v.rst       = rs;
        v.req       = r;
        v.done      = d;
        v.exp_valid = ev;
        v.exp_idx   = ei;
        v.exp_cnt   = ec;
        vecs.push_back(v);
    endfunction

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;

        // Idle after reset, single grant, and pointer advance to 1.
        for (int i = 0; i < 5; i++) addVec(i == 0, 16'h0000, 1'b0, 1'b0, 0, 0);
        addVec(0, 16'h0001, 1'b0, 1'b1, 0, 1);
        addVec(0, 16'h0000, 1'b1, 1'b0, 0, 1);
        addVec(0, 16'hFFFF, 1'b0, 1'b1, 1, 2);
        addVec(0, 16'h0000, 1'b1, 1'b0, 1, 2);
        // Full rotation with all requesting: 0..15 then 0, count reaches 17.
        for (int g = 0; g < 17; g++) begin
            addVec(g == 0, 16'hFFFF, 1'b0, 1'b1, g % 16, g + 1);
            addVec(0, 16'hFFFF, 1'b1, 1'b0, g % 16, g + 1);
        end
        // Pointer at 5 skips idx 4 and wraps to 0; req changes during OWN are ignored.
        addVec(1, 16'h0010, 1'b0, 1'b1, 4, 1);
        addVec(0, 16'h0000, 1'b1, 1'b0, 4, 1);
        addVec(0, 16'h0011, 1'b0, 1'b1, 0, 2);
        addVec(0, 16'hFFFF, 1'b0, 1'b1, 0, 2);
        addVec(0, 16'h0000, 1'b0, 1'b1, 0, 2);
        addVec(0, 16'h0000, 1'b1, 1'b0, 0, 2);
        addVec(0, 16'h0000, 1'b1, 1'b0, 0, 2);

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) doReset();
            applyStimulus(vecs[i].req, vecs[i].done);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_idx,
                        vecs[i].exp_cnt, 1'b0);
        end

        // Asynchronous reset while owning idx 9, then restart from pointer 0.
        doReset();
        applyStimulus(16'h0200, 1'b0);
        checkOutput("own_idx9", 1'b1, 9, 1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 0, 0, 1'b0);
        #1;
        rst_n = 1'b1;
        applyStimulus(16'hFFFF, 1'b0);
        checkOutput("after_reset_ptr0", 1'b1, 0, 1, 1'b0);

        // Holding request with done low.
        doReset();
        applyStimulus(16'h0008, 1'b0);
        checkOutput("hold_first", 1'b1, 3, 1, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int c = 2; c <= MAX_HOLD; c++) begin
            applyStimulus(16'h0008, 1'b0);
            checkOutput($sformatf("hold_cycle%0d", c), 1'b1, 3, 1, 1'b0);
        end
        applyStimulus(16'h0008, 1'b0);
        checkOutput("timeout_pulse", 1'b0, 3, 1, 1'b1);
        applyStimulus(16'h0008, 1'b0);
        checkOutput("regrant_after_timeout", 1'b1, 3, 2, 1'b0);
        for (int c = 2; c <= MAX_HOLD; c++) begin
            applyStimulus(16'h0008, 1'b0);
            checkOutput($sformatf("rehold_cycle%0d", c), 1'b1, 3, 2, 1'b0);
        end
        applyStimulus(16'h0008, 1'b1);
        checkOutput("done_beats_timeout", 1'b0, 3, 2, 1'b0);
`else
        for (int c = 2; c <= 30; c++) begin
            applyStimulus(16'h0008, 1'b0);
            checkOutput($sformatf("hold_cycle%0d", c), 1'b1, 3, 1, 1'b0);
        end
`endif

        // Randomized traffic against the model.
        doReset();
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] r;
            bit          d;
            r = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom & $urandom);
            d = ($urandom_range(0, 2) == 0);
            modelUpdate(r, d);
            applyStimulus(r, d);
            checkOutput($sformatf("rand%0d", n), m_own, m_idx, m_cnt, m_to);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
